// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring integer divider for DIV/DIVU
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                sgn_q, sgn_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  logic [DATA_W:0]     shifted;
  logic                q_bit;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  // Partial remainder with the next dividend bit shifted in; may need DATA_W+1 bits
  // when the divisor is above 2^(DATA_W-1).
  assign shifted = {rem_q, dvd_q[DATA_W-1]};
  assign q_bit   = (shifted >= {1'b0, dvs_q});
  // The true difference is below the divisor whenever q_bit is set, so DATA_W bits hold it.
  assign diff    = shifted[DATA_W-1:0] - dvs_q;

  assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  assign quot_fix = (sgn_q && (s1_q ^ s2_q)) ? -dvd_q : dvd_q;
  assign rem_fix  = (sgn_q && s1_q) ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = '0;
    ready_d  = 1'b0;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BY_ZERO;
          end else begin
            state_d = ON;
            cnt_d   = '0;
            dvd_d   = abs1;
            dvs_d   = abs2;
            rem_d   = '0;
            sgn_d   = signed_div_i;
            s1_d    = opdata1_i[DATA_W-1];
            s2_d    = opdata2_i[DATA_W-1];
          end
        end
      end
      // The zero result is published from END, one edge after entering it.
      BY_ZERO: state_d = END;
      ON: begin
        if (annul_i || !start_i) begin
          state_d = FREE;
        end else if (cnt_q != CNT_DONE) begin
          // Dividend register doubles as the quotient: bits leave the top, quotient bits enter the bottom.
          dvd_d = {dvd_q[DATA_W-2:0], q_bit};
          rem_d = q_bit ? diff : shifted[DATA_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = END;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end
      END: begin
        if (start_i) begin
          result_d = result_o;
          ready_d  = 1'b1;
        end else begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         signed_div_i;
  logic [W-1:0] opdata1_i;
  logic [W-1:0] opdata2_i;
  logic         start_i;
  logic         annul_i;
  logic [2*W-1:0] result_o;
  logic         ready_o;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  typedef struct {
    string       name;
    logic [63:0] res;
    int          accept;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o retires the oldest outstanding request.
  always @(negedge clk) begin
    if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got ready_o=1 at cycle %0d expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, result_o, mon_e.res);
        check({mon_e.name, "_latency"}, 64'(cyc - mon_e.accept), 64'(mon_e.lat));
      end
    end
    prev_ready = ready_o;
  end

  task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] res, input int lat);
    exp_t e;
    int   t;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    e.name = name; e.res = res; e.accept = cyc + 1; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    check({name, "_accept_ready"}, 64'(ready_o), 64'd0);
    opdata1_i = ~a; opdata2_i = ~b ^ 32'h5; signed_div_i = ~sgn;
    t = 0;
    while (ready_o !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (ready_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ready_o after %0d cycles expected ready_o=1", name, t);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      annul_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check({name, "_hold_result"}, result_o, res);
      check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      annul_i = 1'b0;
    end
    start_i = 1'b0;
    @(negedge clk);
    check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({name, "_drop_result"}, result_o, 64'd0);
  endtask

  task automatic quiet(input string name, input int n);
    logic saw;
    saw = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o !== 1'b0 || result_o !== 64'd0) saw = 1'b1;
    end
    check(name, 64'(saw), 64'd0);
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;

    do_div("u_100_7",    1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 33);
    do_div("s_m7_2",     1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    do_div("s_7_m2",     1'b1, 32'h7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33);
    do_div("u_fff9_2",   1'b0, 32'hFFFFFFF9,   32'h2,          {32'h1, 32'h7FFFFFFC}, 33);
    do_div("u_div0",     1'b0, 32'h1234,       32'h0,          64'd0, 2);
    do_div("s_div0",     1'b1, 32'h1234,       32'h0,          64'd0, 2);

    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    quiet("annul_quiet", 40);
    do_div("u_1000_3_after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

    start_op(1'b0, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    quiet("drop_start_quiet", 40);

    start_op(1'b1, 32'hFFFFFFF9, 32'h2);
    repeat (20) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    quiet("midrst_quiet", 40);
    do_div("u_1000_3_after_rst", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    quiet("start_with_annul_quiet", 40);

    do_div("s_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    do_div("s_m1_1",     1'b1, 32'hFFFFFFFF, 32'h1,        {32'h0, 32'hFFFFFFFF}, 33);
    do_div("u_ffff_1",   1'b0, 32'hFFFFFFFF, 32'h1,        {32'h0, 32'hFFFFFFFF}, 33);
    do_div("u_5_9",      1'b0, 32'd5,        32'd9,        {32'd5, 32'd0}, 33);
    do_div("u_big_dvs",  1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h0}, 33);
    do_div("u_msb_dvs",  1'b0, 32'hFFFFFFFF, 32'h80000000, {32'h7FFFFFFF, 32'h1}, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle restoring integer divider consumed by the execute stage for DIV/DIVU.
- The execute stage holds start_i high and stalls the pipeline until ready_o rises. It then writes result_o into HI/LO.
- Supports signed and unsigned division, divide-by-zero, and annulment (branch flush or exception) mid-operation.

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W; result width is 2*DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance
- opdata1_i  in  DATA_W  dividend; sampled at start acceptance
- opdata2_i  in  DATA_W  divisor; sampled at start acceptance
- start_i  in  1  request; held high by the execute stage while stalled
- annul_i  in  1  abort the current operation (flush)
- result_o  out  2*DATA_W  {remainder, quotient}: [63:32] goes to HI, [31:0] goes to LO
- ready_o  out  1  result_o valid

Behaviour:
- All state and outputs are registered. rst=1 at an edge gives: state FREE, cnt=0, result_o=0, ready_o=0. rst=1 mid-operation discards all work.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i==0 → BY_ZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 → ON with cnt=0.
  - On the ON transition, latch the operands. When signed_div_i=1, latch the absolute value of each operand (two's complement negate if bit31=1). Also latch signed_div_i and both operand sign bits.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BY_ZERO: next edge → END with result_o=0, ready_o=1.
- ON:
  - annul_i=1 or start_i=0 → FREE; ready_o stays 0; result_o=0.
  - Else, if cnt!=DATA_W, perform one restoring step and cnt+=1:
    - Compute the trial value {1'b0, partial_rem} − {1'b0, divisor}, where partial_rem is the current partial remainder.
    - Negative (borrow set): shift the quotient bit 0 in and keep partial_rem.
    - Non-negative: partial_rem = trial value, shift 1 in.
    - Quotient bits are produced MSB first from the shifted dividend.
  - Else (cnt==DATA_W) → END and register result_o:
    - Quotient is negated if the latched signed flag is set and the operand signs differ.
    - Remainder is negated if the latched signed flag is set and the dividend sign is 1.
    - Set ready_o=1.
- END:
  - Hold result_o and ready_o=1 while start_i=1.
  - start_i=0 → FREE, ready_o=0, result_o=0.
  - annul_i in END is ignored; the result stays until start_i drops.
- Latency: the edge that accepts start is E0. The non-zero path shows ready_o=1 after edge E(DATA_W+1), i.e. 33 cycles. Divide-by-zero shows ready_o=1 after E2.
- Operand changes after acceptance are ignored.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No exception is raised.
- start_i=1 & annul_i=1 in the same FREE cycle: the start is not accepted.
- A new operation is only accepted from FREE, which requires at least one cycle with start_i=0 after END.
- ready_o never asserts in the cycle a request is accepted.

Test Plan:
- Unsigned 100/7: signed_div_i=0, start_i held → ready_o rises 33 cycles after acceptance; result_o={32'd2, 32'd14}. Drop start_i → ready_o=0 and result_o=0 next cycle.
- Signed −7/2 (0xFFFFFFF9, 0x2) → result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/−2 → {0x00000001, 0xFFFFFFFD}. Unsigned 0xFFFFFFF9/2 → {0x1, 0x7FFFFFFC}.
- Divide by zero: 0x1234/0 in either mode → ready_o after 2 cycles; result_o=0.
- Annul: start 1000/3, pulse annul_i at cycle 10 → state FREE and ready_o stays 0. Re-request 1000/3 → {1, 333} after 33 cycles. Also drop start_i mid-ON → abort the same way.
- Reset mid-operation: rst=1 at cycle 20 → ready_o=0, result_o=0. A fresh request completes correctly.
- Corners, signed: 0x80000000/0xFFFFFFFF → {0, 0x80000000}; −1/1 → {0, 0xFFFFFFFF}.
- Corners, unsigned: 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}; 5/9 → {5, 0}.
- Operand changes after acceptance do not alter the result.
